// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle for gray_conv_arbiter: per-channel gray requests in,
// one tagged binary result slot out.
interface gray_conv_arbiter_if #(
  parameter int NCH = 4,
  parameter int W   = 4
);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_gray;
  logic [NCH-1:0]   req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_binary;
  logic [CHW-1:0]   out_ch;
  logic             out_err;

  // Arbiter side
  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_binary, out_ch, out_err
  );

  // Requester / consumer side
  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_binary, out_ch, out_err
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared gray-to-binary converter with a single registered
// output slot tagged by channel index.
// Optional macro GRAY_STEP_CHK_EN: keep per-channel history of the last
// accepted code and flag steps that change more than one bit (out_err).
module gray_conv_arbiter #(
  parameter int NCH = 4,
  parameter int W   = 4
) (
  input logic               clk,
  input logic               rst,
  gray_conv_arbiter_if.slave bus
);
  localparam int CHW = $clog2(NCH);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  slot_state_t    state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic [W-1:0]   out_binary_q, out_binary_d;
  logic           out_err_q, out_err_d;

  logic [CHW:0]   idx;
  logic [CHW-1:0] grant_ch;
  logic           found;
  logic           slot_free;
  logic           accept;
  logic [NCH-1:0] grant_oh;
  logic [W-1:0]   sel_gray;
  logic [W-1:0]   sel_binary;
  logic           err_new;

  // Round-robin search: first valid channel at or after ptr, modulo NCH
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    idx      = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, ptr_q} + (CHW+1)'(i);
      if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
      if (!found && bus.req_valid[idx[CHW-1:0]]) begin
        found    = 1'b1;
        grant_ch = idx[CHW-1:0];
      end
    end
  end

  // Reset blocks the handshake so nothing is consumed in a reset cycle
  assign slot_free = (state_q == SLOT_EMPTY) || bus.out_ready;
  assign accept    = !rst && slot_free && found;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign grant_oh[gi] = accept && (grant_ch == CHW'(gi));
  end
  assign bus.req_ready = grant_oh;

  assign sel_gray = bus.req_gray[grant_ch*W +: W];

  // Binary bit i is the XOR of all gray bits at or above i (no ripple chain)
  for (genvar gi = 0; gi < W; gi++) begin : g_conv
    assign sel_binary[gi] = ^(sel_gray >> gi);
  end

`ifdef GRAY_STEP_CHK_EN
  logic [NCH*W-1:0] last_flat;
  logic [NCH-1:0]   seen_flat;
  logic [W-1:0]     step_diff;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_hist
    logic [W-1:0] last_q, last_d;
    logic         seen_q, seen_d;

    // Capture the code of every accept granted to this channel
    always_comb begin
      last_d = last_q;
      seen_d = seen_q;
      if (grant_oh[gi]) begin
        last_d = sel_gray;
        seen_d = 1'b1;
      end
    end

    // History registers, cleared by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        last_q <= '0;
        seen_q <= 1'b0;
      end else begin
        last_q <= last_d;
        seen_q <= seen_d;
      end
    end

    assign last_flat[gi*W +: W] = last_q;
    assign seen_flat[gi]        = seen_q;
  end

  assign step_diff = sel_gray ^ last_flat[grant_ch*W +: W];
  assign err_new   = seen_flat[grant_ch] && ($countones(step_diff) > 1);
`else
  assign err_new = 1'b0;
`endif

  // Slot and pointer next-state: refill on accept, drain on out_ready, else hold
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    out_ch_d     = out_ch_q;
    out_binary_d = out_binary_q;
    out_err_d    = out_err_q;
    if (accept) begin
      state_d      = SLOT_FULL;
      out_binary_d = sel_binary;
      out_ch_d     = grant_ch;
      out_err_d    = err_new;
      ptr_d        = (grant_ch == CHW'(NCH-1)) ? '0 : grant_ch + 1'b1;
    end else if (bus.out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SLOT_EMPTY;
      ptr_q        <= '0;
      out_ch_q     <= '0;
      out_binary_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      out_ch_q     <= out_ch_d;
      out_binary_q <= out_binary_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.out_valid  = (state_q == SLOT_FULL);
  assign bus.out_binary = out_binary_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_err    = out_err_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed testbench for gray_conv_arbiter (NCH=4, W=4).
module tb_gray_conv_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gray_conv_arbiter_if #(.NCH(4), .W(4)) bus ();

  gray_conv_arbiter #(.NCH(4), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] t1_gray [7];
  logic [3:0] t1_bin  [7];
  logic [3:0] k_bin   [4];
  logic [3:0] exp_oh;
  logic [3:0] t5_order [3];
  logic [3:0] t6_gray [4];
  logic       t6_err  [4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_gray(input int ch, input logic [3:0] g);
    bus.req_gray[ch*4 +: 4] = g;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    t1_gray  = '{4'b0000, 4'b1010, 4'b0110, 4'b1110, 4'b0111, 4'b1100, 4'b1101};
    t1_bin   = '{4'b0000, 4'b1100, 4'b0100, 4'b1011, 4'b0101, 4'b1000, 4'b1001};
    k_bin    = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    t5_order = '{4'd3, 4'd1, 4'd3};
    t6_gray  = '{4'b0000, 4'b0001, 4'b0111, 4'b0111};
`ifdef GRAY_STEP_CHK_EN
    t6_err   = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
    t6_err   = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_gray  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_binary", 32'(bus.out_binary), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;

    // Single channel sequence on ch0
    for (int i = 0; i < 7; i++) begin
      bus.req_valid = 4'b0001;
      set_gray(0, t1_gray[i]);
      #1;
      chk($sformatf("t1_ready_%0d", i), 32'(bus.req_ready), 32'h1);
      tick();
      chk($sformatf("t1_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t1_bin_%0d", i), 32'(bus.out_binary), 32'(t1_bin[i]));
      chk($sformatf("t1_ch_%0d", i), 32'(bus.out_ch), 32'd0);
    end
    bus.req_valid = '0;
    tick();
    chk("t1_drain_valid", 32'(bus.out_valid), 32'd0);

    // All four channels, fairness from ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_gray(k, 4'(k));
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      #1;
      chk($sformatf("t2_ready_%0d", i), 32'(bus.req_ready), 32'(exp_oh));
      tick();
      chk($sformatf("t2_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t2_ch_%0d", i), 32'(bus.out_ch), 32'(i % 4));
      chk($sformatf("t2_bin_%0d", i), 32'(bus.out_binary), 32'(k_bin[i % 4]));
    end

    // Backpressure: fill with ch2 gray 1101, then stall with ch1 waiting
    bus.req_valid = 4'b0100;
    set_gray(2, 4'b1101);
    set_gray(1, 4'b0011);
    tick();
    chk("t3_fill_bin", 32'(bus.out_binary), 32'h9);
    chk("t3_fill_ch", 32'(bus.out_ch), 32'd2);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_stall_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      tick();
      chk($sformatf("t3_stall_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t3_stall_bin_%0d", i), 32'(bus.out_binary), 32'h9);
      chk($sformatf("t3_stall_ch_%0d", i), 32'(bus.out_ch), 32'd2);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("t3_release_ch", 32'(bus.out_ch), 32'd1);
    chk("t3_release_bin", 32'(bus.out_binary), 32'h2);

    // Reset mid-stream: slot full, all requests valid
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("t4_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t4_rst_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    chk("t4_first_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("t4_first_ch", 32'(bus.out_ch), 32'd1);

    // Skip and wrap: ptr=2 with ch1 and ch3 valid
    for (int i = 0; i < 3; i++) begin
      exp_oh = 4'b0001 << t5_order[i];
      #1;
      chk($sformatf("t5_ready_%0d", i), 32'(bus.req_ready), 32'(exp_oh));
      tick();
      chk($sformatf("t5_ch_%0d", i), 32'(bus.out_ch), 32'(t5_order[i]));
    end

    // Gray step check on ch0
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_gray(0, t6_gray[i]);
      tick();
      chk($sformatf("t6_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t6_err_%0d", i), 32'(bus.out_err), 32'(t6_err[i]));
    end
    bus.req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
